// File: rtl/regfile_mp.sv
// Parametrised multi-read-port integer register file with optional hardwired r0,
// write-to-read bypass and a row-at-a-time clear engine (no parallel array reset).
module regfile_mp #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NREGS   = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned NRD     = 2,
    parameter int unsigned ZERO_R0 = 1,
    parameter int unsigned BYPASS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_req,
    output logic                 busy,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [XLEN-1:0]      wr_data,
    output logic                 wr_drop
);

    localparam int unsigned PW = AW + 1;
    localparam int unsigned IW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [PW-1:0] NREGS_W = PW'(NREGS);
    localparam logic [PW-1:0] LAST    = PW'(NREGS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [XLEN-1:0]   mem [NREGS];

    logic wr_in_range;
    logic wr_is_r0;
    logic wr_commit;
    logic sweep;

    assign wr_in_range = ({1'b0, wr_addr} < NREGS_W);
    assign wr_is_r0    = (ZERO_R0 != 0) && (wr_addr == '0);
    assign busy        = ~rst | (state == CLEAR);
    assign wr_drop     = wr_en & (busy | clr_req | ~wr_in_range);
    assign wr_commit   = wr_en & ~busy & ~clr_req & wr_in_range & ~wr_is_r0;
    assign sweep       = rst & ~clr_req & (state == CLEAR);

    // Clear engine: a request (or reset) restarts the sweep without clearing a row that edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else if (clr_req) begin
            state <= CLEAR;
            ptr   <= '0;
        end else if (state == CLEAR) begin
            ptr <= ptr + PW'(1);
            if (ptr == LAST) begin
                state <= IDLE;
            end
        end
    end

    // Single array write port shared by the sweep and normal writes (never both in one cycle)
    always_ff @(posedge clk) begin
        if (sweep) begin
            mem[IW'(ptr)] <= '0;
        end else if (wr_commit) begin
            mem[IW'(wr_addr)] <= wr_data;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] val;

        assign addr = rd_addr[i*AW +: AW];

        always_comb begin
            val = '0;
            if (!busy && ({1'b0, addr} < NREGS_W) && !((ZERO_R0 != 0) && (addr == '0))) begin
                if ((BYPASS != 0) && wr_commit && (wr_addr == addr)) begin
                    val = wr_data;
                end else begin
                    val = mem[IW'(addr)];
                end
            end
        end

        assign rd_data[i*XLEN +: XLEN] = val;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: four configurations share one stimulus stream
// (a: default, b: no bypass, c: r0 writable, d: 24 registers).
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_req;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [9:0]  rd_addr;

    logic        busy_a, busy_b, busy_c, busy_d;
    logic        drop_a, drop_b, drop_c, drop_d;
    logic [63:0] rdd_a, rdd_b, rdd_c, rdd_d;

    assign rd_addr = {ra1, ra0};

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .ZERO_R0(1), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_a), .rd_addr(rd_addr),
        .rd_data(rdd_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(drop_a));
    regfile_mp #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .ZERO_R0(1), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b), .rd_addr(rd_addr),
        .rd_data(rdd_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(drop_b));
    regfile_mp #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .ZERO_R0(0), .BYPASS(1)) u_c (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_c), .rd_addr(rd_addr),
        .rd_data(rdd_c), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(drop_c));
    regfile_mp #(.XLEN(32), .NREGS(24), .AW(5), .NRD(2), .ZERO_R0(1), .BYPASS(1)) u_d (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_d), .rd_addr(rd_addr),
        .rd_data(rdd_d), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(drop_d));

    typedef struct {
        string       name;
        int          dut;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] ea0;
        logic [31:0] ea1;
        logic [31:0] eb0;
        logic [31:0] ec0;
        logic [31:0] ed0;
        logic        edd;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[10];
    int   passed = 0;
    int   total  = 0;

    // sig: 0 = port0 data, 1 = port1 data, 2 = busy, 3 = wr_drop
    function automatic logic [31:0] actual(int d, int s);
        logic [63:0] r;
        logic        b;
        logic        w;
        case (d)
            0:       begin r = rdd_a; b = busy_a; w = drop_a; end
            1:       begin r = rdd_b; b = busy_b; w = drop_b; end
            2:       begin r = rdd_c; b = busy_c; w = drop_c; end
            default: begin r = rdd_d; b = busy_d; w = drop_d; end
        endcase
        case (s)
            0:       return r[31:0];
            1:       return r[63:32];
            2:       return {31'b0, b};
            default: return {31'b0, w};
        endcase
    endfunction

    task automatic push(input string name, input int d, input int s, input logic [31:0] e);
        exp_t x;
        x.name = name;
        x.dut  = d;
        x.sig  = s;
        x.exp  = e;
        sbq.push_back(x);
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] e);
        total++;
        if (act !== e) begin
            $display("FAIL %s: got %h, expected %h", name, act, e);
        end else begin
            passed++;
        end
    endtask

    // Drain the scoreboard at the falling edge, where combinational outputs are settled
    task automatic chk();
        exp_t x;
        @(negedge clk);
        while (sbq.size() > 0) begin
            x = sbq.pop_front();
            check_val($sformatf("%s[dut%0d.sig%0d]", x.name, x.dut, x.sig), actual(x.dut, x.sig), x.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(input int wr_cycles, input string name, input int exp_a, input int exp_d);
        int ca;
        int cd;
        ca = 0;
        cd = 0;
        for (int n = 0; n < 200 && (busy_a || busy_d); n++) begin
            if (busy_a) ca++;
            if (busy_d) cd++;
            wr_en   = (n < wr_cycles);
            wr_addr = 5'd5;
            wr_data = 32'h55;
            if (n < wr_cycles) begin
                push({name, "_drop"}, 0, 3, 32'd1);
                push({name, "_drop"}, 3, 3, 32'd1);
                chk();
            end
            tick();
        end
        wr_en = 1'b0;
        check_val({name, "_busy_cycles_a"}, 32'(ca), 32'(exp_a));
        check_val({name, "_busy_cycles_d"}, 32'(cd), 32'(exp_d));
    endtask

    initial begin
        vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vt[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vt[2] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd5,  32'h12345678, 32'hDEADBEEF, 32'h0,        32'h12345678, 32'h12345678, 1'b0};
        vt[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  32'h0,        32'h12345678, 32'h0,        32'hFFFFFFFF, 32'h0,        1'b0};
        vt[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  32'h0,        32'h12345678, 32'h0,        32'hFFFFFFFF, 32'h0,        1'b0};
        vt[5] = '{1'b1, 5'd31, 32'h1,        5'd31, 5'd30, 32'h1,        32'h0,        32'h0,        32'h1,        32'h0,        1'b1};
        vt[6] = '{1'b1, 5'd5,  32'hCAFE,     5'd5,  5'd31, 32'hCAFE,     32'h1,        32'hDEADBEEF, 32'hCAFE,     32'hCAFE,     1'b0};
        vt[7] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hCAFE,     32'hCAFE,     32'hCAFE,     32'hCAFE,     32'hCAFE,     1'b0};
        vt[8] = '{1'b1, 5'd30, 32'h77,       5'd30, 5'd30, 32'h77,       32'h77,       32'h0,        32'h77,       32'h0,        1'b1};
        vt[9] = '{1'b0, 5'd0,  32'h0,        5'd30, 5'd30, 32'h77,       32'h77,       32'h77,       32'h77,       32'h0,        1'b0};

        rst = 1'b0; clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; ra0 = '0; ra1 = '0;
        tick();
        tick();
        wr_en = 1'b1; ra0 = 5'd5;
        push("rst_busy", 0, 2, 32'd1);
        push("rst_rd0",  0, 0, 32'd0);
        push("rst_drop", 0, 3, 32'd1);
        push("rst_drop", 3, 3, 32'd1);
        chk();
        tick();
        wr_en = 1'b0;

        // Release reset: sweep length and dropped writes during it
        rst = 1'b1;
        count_busy(20, "init", 32, 24);

        for (int i = 0; i < 32; i++) begin
            ra0 = 5'(i); ra1 = 5'(31 - i);
            push("init_zero", 0, 0, 32'd0);
            push("init_zero", 0, 1, 32'd0);
            chk();
            tick();
        end

        for (int i = 0; i < 10; i++) begin
            wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd; ra0 = vt[i].r0; ra1 = vt[i].r1;
            push($sformatf("vec%0d_a0", i), 0, 0, vt[i].ea0);
            push($sformatf("vec%0d_a1", i), 0, 1, vt[i].ea1);
            push($sformatf("vec%0d_b0", i), 1, 0, vt[i].eb0);
            push($sformatf("vec%0d_c0", i), 2, 0, vt[i].ec0);
            push($sformatf("vec%0d_d0", i), 3, 0, vt[i].ed0);
            push($sformatf("vec%0d_dropa", i), 0, 3, 32'd0);
            push($sformatf("vec%0d_dropd", i), 3, 3, {31'b0, vt[i].edd});
            chk();
            tick();
        end
        wr_en = 1'b0;

        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
            tick();
        end
        wr_en = 1'b0; ra0 = 5'd17; ra1 = 5'd3;
        push("load_r17", 0, 0, 32'd17);
        push("load_r3",  0, 1, 32'd3);
        chk();
        tick();

        // Clear request with a colliding write: write dropped, no bypass of it
        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAA; ra0 = 5'd3;
        push("clr_drop",  0, 3, 32'd1);
        push("clr_busy0", 0, 2, 32'd0);
        push("clr_rd3",   0, 0, 32'd3);
        chk();
        tick();
        clr_req = 1'b0; wr_en = 1'b0;
        count_busy(0, "clr", 32, 24);
        for (int i = 0; i < 32; i++) begin
            ra0 = 5'(i); ra1 = 5'(i);
            push("clr_zero", 0, 0, 32'd0);
            chk();
            tick();
        end

        // Restart a sweep 10 cycles in
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        clr_req = 1'b1;
        push("restart_busy", 0, 2, 32'd1);
        chk();
        tick();
        clr_req = 1'b0;
        count_busy(0, "restart", 32, 24);

        // Reset in the middle of a sweep
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        push("midrst_busy", 0, 2, 32'd1);
        chk();
        tick();
        rst = 1'b1;
        count_busy(0, "midrst", 32, 24);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
